fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Write-side controller for the async FIFO memory. It shares the single write
//  port of fifomem among NREQ requesters in the write clock domain, using
//  round-robin arbitration with bounded bursts.
//  It owns the write pointer (binary and Gray) and computes wfull from the
//  read pointer after it has been synchronised into this domain.
//  It drives fifomem's winc/waddr/wdata/wfull directly and exports the Gray
//  pointer to the read-side synchroniser.
// PARAMETERS
//  DATASIZE  8  data word width; equals fifomem DATASIZE
//  ADDRSIZE  4  memory address bits; equals fifomem ADDRSIZE; must be >= 2
//  NREQ      4  number of write requesters; must be >= 2
//  MAXBURST  4  maximum writes per grant before rearbitration; must be >= 1
// PORTS
//  wclk      in   1              write-domain clock; all state on posedge
//  wrst      in   1              synchronous, active-high reset
//  req       in   NREQ           req[i]: requester i has a word on wdata_in slice i
//  wdata_in  in   NREQ*DATASIZE  slice i = bits [i*DATASIZE +: DATASIZE]
//  wq2_rptr  in   ADDRSIZE+1     Gray read pointer, already 2-flop synced to wclk
//  ack       out  NREQ           one-hot pulse: word of requester i written this cycle
//  winc      out  1              write strobe to fifomem
//  waddr     out  ADDRSIZE       write address to fifomem = wbin[ADDRSIZE-1:0]
//  wdata     out  DATASIZE       owner's wdata_in slice
//  wfull     out  1              registered full flag, also fed to fifomem
//  wptr      out  ADDRSIZE+1     registered Gray write pointer, to read-side sync
//  owner     out  $clog2(NREQ)   index of the current grant holder (valid in GRANT)
// BEHAVIOUR
//  Reset (wrst high at posedge): state=IDLE, wbin=0, wptr=0, wfull=0,
//   burst_cnt=0, owner=0, rr_last=NREQ-1 (so req[0] has top priority).
//   winc and ack are forced to 0 in any cycle where wrst=1.
//   Reset mid-burst drops the grant. The in-flight word is not written.
//  FSM IDLE:
//   - If req!=0, select the first set bit searching upward from rr_last+1,
//     wrapping modulo NREQ.
//   - Register that index into owner, set rr_last=owner, clear burst_cnt,
//     and go to GRANT.
//   - No write occurs in IDLE, so grant latency from req is 1 cycle.
//  FSM GRANT:
//   - winc = req[owner] & ~wfull & ~wrst, combinationally.
//   - ack[owner] = winc. All other ack bits are 0.
//   - On winc: wbin+=1 and burst_cnt+=1.
//   - Exit to IDLE when req[owner]==0, or when a write occurs with
//     burst_cnt==MAXBURST-1. Otherwise stay in GRANT.
//   - While wfull=1 with req[owner]=1: hold grant, winc=0, counters frozen.
//  Handshake: a requester holds req and data stable until it sees ack. On ack
//   it may present its next word (req still high) or drop req in the next cycle.
//   Requesters must not withdraw req before ack.
//   A non-owner's req is ignored until the next IDLE cycle.
//  Throughput: at most MAXBURST words per grant, then one IDLE bubble cycle.
//  Pointer arithmetic:
//   - wbin is ADDRSIZE+1 bits and wraps modulo 2^(ADDRSIZE+1).
//   - wbinnext = wbin + winc.
//   - wgnext = (wbinnext>>1) ^ wbinnext.
//   - wptr <= wgnext.
//  Full flag, registered:
//   - wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
//     wq2_rptr[ADDRSIZE-2:0]}).
//   - wfull asserts in the same cycle the 2^ADDRSIZE-th unread word is written.
//   - wfull deasserts one wclk after wq2_rptr advances.
//  Simultaneous events: a write and an rptr update in the same cycle are both
//   folded into the wfull compare; no write is lost and no overflow occurs.
//  Only the owner's req can produce a write, so a single winc per cycle is
//   guaranteed.
// TESTING
//  T1 reset: hold wrst=1 for 2 cycles with req=4'b1111
//     -> ack=0, winc=0, wptr=0, wfull=0, owner=0.
//  T2 round-robin: req=4'b1111 held, each requester drops req after 1 ack,
//     MAXBURST=4 -> ack order 0,1,2,3,0.
//     Each ack is preceded by one IDLE cycle.
//  T3 burst cap: req[2] held high continuously, others 0, MAXBURST=4
//     -> 4 consecutive acks, 1 bubble, then regrant to 2.
//     waddr runs 0,1,2,3,(bubble),4.
//  T4 full: wq2_rptr=0, req[0] high with 16 words (ADDRSIZE=4)
//     -> wfull=1 at the 16th write, 17th word not acked, winc=0.
//     Then set wq2_rptr=5'b00001 -> wfull=0 one cycle later, and the 17th
//     word is written to waddr=0.
//  T5 wrap: drive 40 writes while advancing wq2_rptr in Gray to track.
//     -> waddr wraps 15->0; wptr follows the Gray sequence through 5'b11000
//     and back to 5'b00000; memory contents match the ack order.
//  T6 reset mid-burst: assert wrst while in GRANT with burst_cnt=2
//     -> no ack that cycle, next state IDLE, wbin=0.
//     Arbitration restarts at req[0].

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO. It arbitrates the single fifomem
// write port among NREQ requesters using round-robin with bounded bursts, owns
// the binary/Gray write pointer, and computes the registered full flag against
// the read pointer already synchronised into the write clock domain.
module fifo_wr_arbiter #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAXBURST = 4
) (
    input  logic                         wclk,
    input  logic                         wrst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*DATASIZE-1:0]     wdata_in,
    input  logic [ADDRSIZE:0]            wq2_rptr,
    output logic [NREQ-1:0]              ack,
    output logic                         winc,
    output logic [ADDRSIZE-1:0]          waddr,
    output logic [DATASIZE-1:0]          wdata,
    output logic                         wfull,
    output logic [ADDRSIZE:0]            wptr,
    output logic [$clog2(NREQ)-1:0]      owner
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned PW = ADDRSIZE + 1;
    localparam int unsigned BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_rr_last;
    logic [BW-1:0]       r_burst_cnt;
    logic [PW-1:0]       r_wbin;
    logic [PW-1:0]       r_wptr;
    logic                r_wfull;

    logic [DATASIZE-1:0] w_slice [NREQ];
    logic [OW-1:0]       w_pick;
    logic                w_pick_found;
    int unsigned         w_pick_idx;
    logic                w_req_any;
    logic                w_req_own;
    logic                w_burst_last;
    logic                w_winc;
    logic [PW-1:0]       w_wbinnext;
    logic [PW-1:0]       w_wgnext;
    logic                w_full_next;

    // Split the flat data bus into one word per requester
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_slice[g] = wdata_in[g*DATASIZE +: DATASIZE];
    end

    // Round-robin pick: first requester above the last grant, wrapping
    always_comb begin
        w_pick       = r_rr_last;
        w_pick_found = 1'b0;
        w_pick_idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_pick_idx = (32'(r_rr_last) + k) % NREQ;
            if (!w_pick_found && req[OW'(w_pick_idx)]) begin
                w_pick       = OW'(w_pick_idx);
                w_pick_found = 1'b1;
            end
        end
    end

    assign w_req_any    = |req;
    assign w_req_own    = req[r_owner];
    assign w_burst_last = (r_burst_cnt == BW'(MAXBURST - 1));

    // Write strobe only for the owner, never while full or in reset
    assign w_winc = (r_state == S_GRANT) & w_req_own & ~r_wfull & ~wrst;

    // Next pointer values and full compare, including any same-cycle write
    assign w_wbinnext  = r_wbin + PW'(w_winc);
    assign w_wgnext    = (w_wbinnext >> 1) ^ w_wbinnext;
    assign w_full_next = (w_wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                       wq2_rptr[ADDRSIZE-2:0]});

    // FSM state register
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: grant on any request, release on drop or burst cap
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_req_own) begin
                    w_state_next = S_IDLE;
                end else if (w_winc && w_burst_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant bookkeeping: owner, round-robin pointer and burst counter
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_owner     <= '0;
            r_rr_last   <= OW'(NREQ - 1);
            r_burst_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_req_any) begin
            r_owner     <= w_pick;
            r_rr_last   <= w_pick;
            r_burst_cnt <= '0;
        end else if (w_winc) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
        end
    end

    // Write pointer (binary and Gray) and registered full flag
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
        end else begin
            r_wbin  <= w_wbinnext;
            r_wptr  <= w_wgnext;
            r_wfull <= w_full_next;
        end
    end

    // One-hot acknowledge to the owner on each write
    always_comb begin
        ack = '0;
        if (w_winc) begin
            ack[r_owner] = 1'b1;
        end
    end

    assign winc  = w_winc;
    assign waddr = r_wbin[ADDRSIZE-1:0];
    assign wdata = w_slice[r_owner];
    assign wfull = r_wfull;
    assign wptr  = r_wptr;
    assign owner = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed tests queue expected writes,
// a negedge monitor pops and compares each write the DUT performs.
module tb_fifo_wr_arbiter;

    localparam int DS = 8;
    localparam int AS = 4;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              wclk = 1'b0;
    logic              wrst;
    logic [NR-1:0]     req;
    logic [NR*DS-1:0]  wdata_in;
    logic [AS:0]       wq2_rptr;
    logic [NR-1:0]     ack;
    logic              winc;
    logic [AS-1:0]     waddr;
    logic [DS-1:0]     wdata;
    logic              wfull;
    logic [AS:0]       wptr;
    logic [1:0]        owner;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .DATASIZE (DS),
        .ADDRSIZE (AS),
        .NREQ     (NR),
        .MAXBURST (MB)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .wdata_in (wdata_in),
        .wq2_rptr (wq2_rptr),
        .ack      (ack),
        .winc     (winc),
        .waddr    (waddr),
        .wdata    (wdata),
        .wfull    (wfull),
        .wptr     (wptr),
        .owner    (owner)
    );

    typedef struct {
        int          idx;
        logic [DS-1:0] data;
        logic [AS:0] wbin;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   wr_count = 0;
    int   cyc = 0;
    int   wr_cycles[$];
    int   words_left[NR];
    int   seq[NR];
    bit   track = 1'b0;

    function automatic logic [DS-1:0] dval(int i, int k);
        return DS'((i << 6) + k);
    endfunction

    function automatic logic [AS:0] gray(logic [AS:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int i, logic [DS-1:0] d, logic [AS:0] b);
        sb.push_back('{idx: i, data: d, wbin: b});
    endtask

    task automatic apply_data();
        for (int i = 0; i < NR; i++) wdata_in[i*DS +: DS] = dval(i, seq[i]);
    endtask

    task automatic arm(int i, int n);
        words_left[i] = n;
        seq[i]        = 0;
        req[i]        = 1'b1;
        apply_data();
    endtask

    // One clock of requester behaviour: advance or drop after each ack
    task automatic run_cycle();
        logic [NR-1:0] a;
        @(negedge wclk);
        a = ack;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (a[i]) begin
                seq[i]++;
                words_left[i]--;
                if (words_left[i] <= 0) req[i] = 1'b0;
            end
        end
        apply_data();
        if (track) wq2_rptr = gray(5'(wr_count));
    endtask

    task automatic run_until(int target, int budget, string name);
        int n = 0;
        while (wr_count < target && n < budget) begin
            run_cycle();
            n++;
        end
        chk(name, 64'(wr_count), 64'(target));
    endtask

    task automatic do_reset();
        req      = '0;
        wrst     = 1'b1;
        wq2_rptr = '0;
        track    = 1'b0;
        for (int i = 0; i < NR; i++) begin
            words_left[i] = 0;
            seq[i]        = 0;
        end
        apply_data();
        repeat (2) @(posedge wclk);
        #1;
        wrst     = 1'b0;
        wr_count = 0;
        wr_cycles.delete();
    endtask

    always @(posedge wclk) cyc <= cyc + 1;

    // Monitor: every write must match the next expected entry
    always @(negedge wclk) begin
        if (winc) begin
            wr_count++;
            wr_cycles.push_back(cyc);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got ack %0h addr %0h expected no write", ack, waddr);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_onehot", 64'(ack), 64'(1) << mon_e.idx);
                chk("owner", 64'(owner), 64'(mon_e.idx));
                chk("wdata", 64'(wdata), 64'(mon_e.data));
                chk("waddr", 64'(waddr), 64'(mon_e.wbin[AS-1:0]));
                chk("wptr_before_write", 64'(wptr), 64'(gray(mon_e.wbin)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        logic [AS:0] b;

        // T1: reset with all requests high
        wrst     = 1'b1;
        req      = '1;
        wdata_in = '0;
        wq2_rptr = '0;
        for (int i = 0; i < NR; i++) begin
            words_left[i] = 0;
            seq[i]        = 0;
        end
        repeat (2) @(posedge wclk);
        #1;
        chk("t1_ack", 64'(ack), 64'(0));
        chk("t1_winc", 64'(winc), 64'(0));
        chk("t1_wptr", 64'(wptr), 64'(0));
        chk("t1_wfull", 64'(wfull), 64'(0));
        chk("t1_owner", 64'(owner), 64'(0));

        // T2: round robin, one word each, then requester 0 again
        for (int i = 0; i < NR; i++) arm(i, 1);
        push(0, 8'h00, 5'd0);
        push(1, 8'h40, 5'd1);
        push(2, 8'h80, 5'd2);
        push(3, 8'hC0, 5'd3);
        wrst = 1'b0;
        run_until(4, 60, "t2_first_round");
        repeat (3) run_cycle();
        push(0, 8'h00, 5'd4);
        arm(0, 1);
        run_until(5, 20, "t2_rr_wrap");
        repeat (3) run_cycle();
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));

        // T3: burst cap of 4 then a single bubble before regrant
        do_reset();
        for (int k = 0; k < 5; k++) push(2, dval(2, k), 5'(k));
        arm(2, 5);
        run_until(5, 60, "t3_writes");
        if (wr_cycles.size() >= 5) begin
            chk("t3_gap01", 64'(wr_cycles[1] - wr_cycles[0]), 64'(1));
            chk("t3_gap23", 64'(wr_cycles[3] - wr_cycles[2]), 64'(1));
            chk("t3_bubble", 64'(wr_cycles[4] - wr_cycles[3]), 64'(2));
        end
        repeat (3) run_cycle();
        chk("t3_sb_empty", 64'(sb.size()), 64'(0));

        // T4: fill to 16, stall, then release by advancing read pointer
        do_reset();
        for (int k = 0; k < 17; k++) push(0, dval(0, k), 5'(k));
        arm(0, 17);
        run_until(16, 80, "t4_fill");
        chk("t4_wfull_set", 64'(wfull), 64'(1));
        for (int n = 0; n < 5; n++) begin
            run_cycle();
            chk("t4_stall_winc", 64'(winc), 64'(0));
            chk("t4_stall_ack", 64'(ack), 64'(0));
        end
        chk("t4_no_17th", 64'(wr_count), 64'(16));
        chk("t4_wptr_full", 64'(wptr), 64'(5'b11000));
        wq2_rptr = 5'b00001;
        run_cycle();
        chk("t4_wfull_clear", 64'(wfull), 64'(0));
        run_until(17, 10, "t4_17th");
        chk("t4_wfull_again", 64'(wfull), 64'(1));
        repeat (2) run_cycle();
        chk("t4_sb_empty", 64'(sb.size()), 64'(0));

        // T5: 40 writes across four requesters with a tracking reader
        do_reset();
        b = '0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++) begin
                for (int k = 0; k < ((r < 2) ? 4 : 2); k++) begin
                    push(i, dval(i, r * 4 + k), b);
                    b = b + 5'd1;
                end
            end
        end
        track = 1'b1;
        for (int i = 0; i < NR; i++) arm(i, 10);
        run_until(40, 300, "t5_writes");
        repeat (3) run_cycle();
        chk("t5_final_wptr", 64'(wptr), 64'(5'b01100));
        chk("t5_final_waddr", 64'(waddr), 64'(8));
        chk("t5_wfull", 64'(wfull), 64'(0));
        chk("t5_sb_empty", 64'(sb.size()), 64'(0));

        // T6: reset in the middle of a burst
        do_reset();
        push(1, dval(1, 0), 5'd0);
        push(1, dval(1, 1), 5'd1);
        arm(1, 3);
        run_until(2, 20, "t6_two_writes");
        wrst = 1'b1;
        arm(0, 1);
        @(negedge wclk);
        chk("t6_ack_in_reset", 64'(ack), 64'(0));
        chk("t6_winc_in_reset", 64'(winc), 64'(0));
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        c0   = cyc;
        chk("t6_wptr", 64'(wptr), 64'(0));
        chk("t6_waddr", 64'(waddr), 64'(0));
        chk("t6_owner", 64'(owner), 64'(0));
        push(0, dval(0, 0), 5'd0);
        push(1, dval(1, 2), 5'd1);
        run_until(4, 20, "t6_restart");
        if (wr_cycles.size() >= 3) begin
            chk("t6_idle_after_reset", 64'(wr_cycles[2] - c0), 64'(1));
        end
        repeat (3) run_cycle();
        chk("t6_sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
